rx_command_sequencer: RTL and testbench

//  Sits between the UART byte receiver and the game logic. Frames received bytes into
//  4-byte commands (opcode, row, col, checksum), validates them, and presents one command
//  at a time to the board controller over a valid/ready handshake. Also reports framing

---
 rtl/rx_command_sequencer_if.sv | 21 ++
 rtl/rx_command_sequencer.sv | 94 +++++++++
 tb/tb_rx_command_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rx_command_sequencer_if.sv
// rx_command_sequencer_if: receiver byte input, command handshake and error reporting
interface rx_command_sequencer_if #(parameter int ROW_W = 4, parameter int COL_W = 4);
  logic [7:0]       rxdata;
  logic             rxfinish;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;
  logic             err_pulse;
  logic [2:0]       err_code;
  logic [7:0]       err_count;
  modport master (
    input  rxdata, rxfinish, cmd_ready,
    output cmd_valid, cmd_op, cmd_row, cmd_col, err_pulse, err_code, err_count
  );
  modport slave (
    output rxdata, rxfinish, cmd_ready,
    input  cmd_valid, cmd_op, cmd_row, cmd_col, err_pulse, err_code, err_count
  );
endinterface

// File: rtl/rx_command_sequencer.sv
// rx_command_sequencer: frames UART bytes into validated 4-byte board commands
module rx_command_sequencer #(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int ROW_W   = 4,
  parameter int COL_W   = 4,
  parameter int TIMEOUT = 100000
) (
  input logic clock,
  input logic reset,
  rx_command_sequencer_if.master bus
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, OP_RCVD, ROW_RCVD, COL_RCVD, CHECK, HOLD} state_t;
  state_t state, state_n;
  logic fin_d, strobe, rcv, abort, take, load, err;
  logic bad_sum, bad_op, bad_rng;
  logic [2:0] code;
  logic [1:0] op_n;
  logic [7:0] op_b, row_b, col_b, sum_b;
  logic [TW-1:0] timer;
  assign strobe  = bus.rxfinish & ~fin_d;
  assign rcv     = state inside {OP_RCVD, ROW_RCVD, COL_RCVD};
  // abort on the edge where the idle count would reach TIMEOUT-1; a byte that same cycle wins
  assign abort   = rcv & ~strobe & (timer == TW'(TIMEOUT - 2));
  assign bad_sum = |(op_b ^ row_b ^ col_b ^ sum_b);
  assign bad_op  = !(op_b inside {8'h52, 8'h46, 8'h4E});
  assign bad_rng = (op_b != 8'h4E) && ((32'(row_b) >= ROWS) || (32'(col_b) >= COLS));
  assign op_n    = op_b == 8'h52 ? 2'd0 : op_b == 8'h46 ? 2'd1 : 2'd2;
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // next state, byte acceptance, frame validation and error selection
  always_comb begin
    state_n = state;
    take = 1'b0;
    load = 1'b0;
    err = 1'b0;
    code = 3'd0;
    case (state)
      IDLE, OP_RCVD, ROW_RCVD, COL_RCVD:
        if (strobe) begin
          take = 1'b1;
          state_n = state_t'(state + 3'd1);
        end else if (abort) begin
          err = 1'b1;
          code = 3'd4;
          state_n = IDLE;
        end
      CHECK: begin
        err = bad_sum | bad_op | bad_rng;
        load = ~err;
        code = bad_sum ? 3'd1 : bad_op ? 3'd2 : 3'd3;
        state_n = err ? IDLE : HOLD;
      end
      HOLD: if (bus.cmd_valid && bus.cmd_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (strobe && (state == CHECK || state == HOLD)) begin
      err = 1'b1;
      code = 3'd5;
    end
  end
  // byte shift register, inter-byte timer, command payload and error reporting
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      fin_d <= 1'b1;
      {op_b, row_b, col_b, sum_b} <= '0;
      timer <= '0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_op <= '0;
      bus.cmd_row <= '0;
      bus.cmd_col <= '0;
      bus.err_pulse <= 1'b0;
      bus.err_code <= '0;
      bus.err_count <= '0;
    end else begin
      fin_d <= bus.rxfinish;
      if (take) {op_b, row_b, col_b, sum_b} <= {row_b, col_b, sum_b, bus.rxdata};
      timer <= (rcv && !strobe && !abort) ? timer + 1'b1 : '0;
      if (load) begin
        bus.cmd_valid <= 1'b1;
        bus.cmd_op <= op_n;
        bus.cmd_row <= row_b[ROW_W-1:0];
        bus.cmd_col <= col_b[COL_W-1:0];
      end else if (bus.cmd_ready) bus.cmd_valid <= 1'b0;
      bus.err_pulse <= err;
      if (err) begin
        bus.err_code <= code;
        bus.err_count <= bus.err_count + {7'd0, bus.err_count != 8'hFF};
      end
    end
endmodule

// File: tb/tb_rx_command_sequencer.sv
// tb_rx_command_sequencer: directed checks of framing, validation, timeout, overrun and reset
module tb_rx_command_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clock = ~clock;
  rx_command_sequencer_if #(.ROW_W(4), .COL_W(4)) bus ();
  rx_command_sequencer #(.ROWS(16), .COLS(16), .ROW_W(4), .COL_W(4), .TIMEOUT(8)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    bus.rxdata = b;
    bus.rxfinish = 1'b0;
    @(negedge clock);
    bus.rxfinish = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask
  task automatic expect_cmd(input string tag, input logic [1:0] op, input logic [3:0] row, col);
    chk({tag, "_valid"}, {7'd0, bus.cmd_valid}, 8'd1);
    chk({tag, "_op"}, {6'd0, bus.cmd_op}, {6'd0, op});
    chk({tag, "_row"}, {4'd0, bus.cmd_row}, {4'd0, row});
    chk({tag, "_col"}, {4'd0, bus.cmd_col}, {4'd0, col});
  endtask
  initial begin
    bus.rxdata = 8'h00;
    bus.rxfinish = 1'b1;
    bus.cmd_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_valid", {7'd0, bus.cmd_valid}, 8'd0);
    chk("rst_pulse", {7'd0, bus.err_pulse}, 8'd0);
    chk("rst_code", {5'd0, bus.err_code}, 8'd0);
    chk("rst_count", bus.err_count, 8'd0);
    reset = 1'b1;
    // valid reveal with ready high: one-cycle valid
    bus.cmd_ready = 1'b1;
    send_frame(8'h52, 8'h03, 8'h05, 8'h54);
    @(negedge clock);
    chk("t1_check_valid", {7'd0, bus.cmd_valid}, 8'd0);
    @(negedge clock);
    expect_cmd("t1", 2'd0, 4'd3, 4'd5);
    chk("t1_pulse", {7'd0, bus.err_pulse}, 8'd0);
    @(negedge clock);
    chk("t1_drop", {7'd0, bus.cmd_valid}, 8'd0);
    chk("t1_count", bus.err_count, 8'd0);
    // bad checksum
    bus.cmd_ready = 1'b0;
    send_frame(8'h46, 8'h02, 8'h02, 8'h45);
    @(negedge clock);
    chk("t2_pre_pulse", {7'd0, bus.err_pulse}, 8'd0);
    @(negedge clock);
    chk("t2_pulse", {7'd0, bus.err_pulse}, 8'd1);
    chk("t2_code", {5'd0, bus.err_code}, 8'd1);
    chk("t2_count", bus.err_count, 8'd1);
    chk("t2_valid", {7'd0, bus.cmd_valid}, 8'd0);
    @(negedge clock);
    chk("t2_pulse_end", {7'd0, bus.err_pulse}, 8'd0);
    chk("t2_code_hold", {5'd0, bus.err_code}, 8'd1);
    // row out of range, then new game ignores range
    send_frame(8'h52, 8'h10, 8'h00, 8'h42);
    repeat (2) @(negedge clock);
    chk("t3_pulse", {7'd0, bus.err_pulse}, 8'd1);
    chk("t3_code", {5'd0, bus.err_code}, 8'd3);
    chk("t3_count", bus.err_count, 8'd2);
    send_frame(8'h4E, 8'hFF, 8'hFF, 8'h4E);
    repeat (2) @(negedge clock);
    expect_cmd("t3n", 2'd2, 4'hF, 4'hF);
    bus.cmd_ready = 1'b1;
    @(negedge clock);
    chk("t3n_drop", {7'd0, bus.cmd_valid}, 8'd0);
    bus.cmd_ready = 1'b0;
    // timeout after two bytes
    send_byte(8'h52);
    send_byte(8'h01);
    repeat (7) @(negedge clock);
    chk("t4_pre_pulse", {7'd0, bus.err_pulse}, 8'd0);
    @(negedge clock);
    chk("t4_pulse", {7'd0, bus.err_pulse}, 8'd1);
    chk("t4_code", {5'd0, bus.err_code}, 8'd4);
    chk("t4_count", bus.err_count, 8'd3);
    send_frame(8'h46, 8'h02, 8'h03, 8'h47);
    repeat (2) @(negedge clock);
    expect_cmd("t4f", 2'd1, 4'd2, 4'd3);
    bus.cmd_ready = 1'b1;
    @(negedge clock);
    chk("t4f_drop", {7'd0, bus.cmd_valid}, 8'd0);
    bus.cmd_ready = 1'b0;
    // overrun while holding
    send_frame(8'h52, 8'h07, 8'h08, 8'h5D);
    repeat (2) @(negedge clock);
    expect_cmd("t5", 2'd0, 4'd7, 4'd8);
    send_byte(8'hAA);
    @(negedge clock);
    chk("t5_pulse", {7'd0, bus.err_pulse}, 8'd1);
    chk("t5_code", {5'd0, bus.err_code}, 8'd5);
    chk("t5_count", bus.err_count, 8'd4);
    expect_cmd("t5_hold", 2'd0, 4'd7, 4'd8);
    bus.cmd_ready = 1'b1;
    @(negedge clock);
    chk("t5_drop", {7'd0, bus.cmd_valid}, 8'd0);
    bus.cmd_ready = 1'b0;
    // accept and overrun on the same edge
    send_frame(8'h4E, 8'h00, 8'h00, 8'h4E);
    repeat (2) @(negedge clock);
    expect_cmd("t5b", 2'd2, 4'd0, 4'd0);
    send_byte(8'h11);
    bus.cmd_ready = 1'b1;
    @(negedge clock);
    chk("t5b_drop", {7'd0, bus.cmd_valid}, 8'd0);
    chk("t5b_pulse", {7'd0, bus.err_pulse}, 8'd1);
    chk("t5b_count", bus.err_count, 8'd5);
    bus.cmd_ready = 1'b0;
    // asynchronous reset mid-frame
    send_byte(8'h52);
    send_byte(8'h03);
    #2 reset = 1'b0;
    #1;
    chk("t6_count", bus.err_count, 8'd0);
    chk("t6_code", {5'd0, bus.err_code}, 8'd0);
    chk("t6_op", {6'd0, bus.cmd_op}, 8'd0);
    chk("t6_valid", {7'd0, bus.cmd_valid}, 8'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_rel_pulse", {7'd0, bus.err_pulse}, 8'd0);
    send_frame(8'h52, 8'h03, 8'h05, 8'h54);
    repeat (2) @(negedge clock);
    expect_cmd("t6f", 2'd0, 4'd3, 4'd5);
    chk("t6f_count", bus.err_count, 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
